// File: rtl/extbusif_6502_mp.sv
// 6502 slave bus interface with NPORTS auto-incrementing data ports, posted-write FIFO
// and a single-outstanding bus master port with bm_ack handshake.
module extbusif_6502_mp #(
  parameter int NPORTS      = 2,
  parameter int ADDR_W      = 20,
  parameter int WFIFO_DEPTH = 4,
  parameter int NIRQ        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              extbus_phi2,
  input  logic              extbus_cs_n,
  input  logic              extbus_rw_n,
  input  logic [3:0]        extbus_a,
  inout  wire  [7:0]        extbus_d,
  output wire               extbus_irq_n,
  output logic [ADDR_W-1:0] bm_addr,
  output logic [7:0]        bm_wrdata,
  input  logic [7:0]        bm_rddata,
  output logic              bm_strobe,
  output logic              bm_write,
  input  logic              bm_ack,
  input  logic [NIRQ-1:0]   irqs
);

  localparam int          FA_W     = $clog2(WFIFO_DEPTH);
  localparam logic [7:0]  ISR_MASK = 8'h80 | 8'((1 << NIRQ) - 1);
  localparam logic [3:0]  DATA_LO  = 4'd6;
  localparam logic [3:0]  DATA_HI  = 4'(6 + NPORTS);
  localparam logic [2:0]  NP       = 3'(NPORTS);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

  state_t state, state_nx;
  logic   issue_wr, issue_rd, done_wr, done_rd;

  logic [SYNC_STAGES-1:0] cs_sync, acc_sync;
  logic                   acc_prev;
  logic [SYNC_STAGES:0][3:0] a_dly;
  logic [SYNC_STAGES:0][7:0] d_dly;
  logic [SYNC_STAGES:0]      rw_dly;

  logic [ADDR_W-1:0] addr    [0:3];
  logic [3:0]        incr    [0:3];
  logic [7:0]        rdlatch [0:3];
  logic [3:0]        decr;
  logic [1:0]        sel;
  logic [7:0]        ien, isr;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_port, act_port;

  logic [ADDR_W+7:0] fifo_mem [0:WFIFO_DEPTH-1];
  logic [FA_W:0]     wp, rp;
  logic              fifo_empty, fifo_full;
  logic [ADDR_W+7:0] fifo_head;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [3:0] inc, input logic dec);
    logic [ADDR_W-1:0] s;
    s = (inc == 4'd0) ? '0 : (ADDR_W'(1) << (inc - 4'd1));
    return dec ? a - s : a + s;
  endfunction

  function automatic logic [ADDR_W-1:0] set_byte(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] idx, input logic [7:0] v);
    logic [23:0] t;
    t = 24'(a);
    case (idx)
      2'd2:    t[19:16] = v[3:0];
      2'd1:    t[15:8]  = v;
      default: t[7:0]   = v;
    endcase
    return t[ADDR_W-1:0];
  endfunction

  // Access strobes are derived from the synchronised PHI2&&!cs_n level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync  <= '0;
      acc_sync <= '0;
      acc_prev <= 1'b0;
      a_dly    <= '0;
      d_dly    <= '0;
      rw_dly   <= '1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], ~extbus_cs_n};
      acc_sync <= {acc_sync[SYNC_STAGES-2:0], extbus_phi2 & ~extbus_cs_n};
      acc_prev <= acc_sync[SYNC_STAGES-1];
      a_dly    <= {a_dly[SYNC_STAGES-1:0], extbus_a};
      d_dly    <= {d_dly[SYNC_STAGES-1:0], extbus_d};
      rw_dly   <= {rw_dly[SYNC_STAGES-1:0], extbus_rw_n};
    end
  end

  logic       acc_start, acc_end;
  logic [3:0] a_s, a_e, a_s_off, a_e_off;
  logic [7:0] d_e;
  logic       wr_en, wr_data, rd_start, push, ovf;
  logic [1:0] wr_port, rd_port_s, ctrl_sel;
  logic [7:0] isr_set, isr_clr;

  assign acc_start = acc_sync[SYNC_STAGES-1] & ~acc_prev & cs_sync[SYNC_STAGES-1];
  assign acc_end   = ~acc_sync[SYNC_STAGES-1] & acc_prev;
  assign a_s       = a_dly[SYNC_STAGES-1];
  assign a_e       = a_dly[SYNC_STAGES];
  assign d_e       = d_dly[SYNC_STAGES];
  assign a_s_off   = a_s - DATA_LO;
  assign a_e_off   = a_e - DATA_LO;
  assign rd_port_s = a_s_off[1:0];
  assign wr_port   = a_e_off[1:0];

  assign wr_en    = acc_end & ~rw_dly[SYNC_STAGES];
  assign wr_data  = wr_en & (a_e >= DATA_LO) & (a_e < DATA_HI);
  assign rd_start = acc_start & rw_dly[SYNC_STAGES-1] & (a_s >= DATA_LO) & (a_s < DATA_HI);
  assign push     = wr_data & ~fifo_full;
  assign ovf      = wr_data & fifo_full;
  assign ctrl_sel = ({1'b0, d_e[1:0]} < NP) ? d_e[1:0] : sel;

  assign isr_set = {ovf, 7'b0} | 8'(irqs);
  assign isr_clr = (wr_en && a_e == 4'd5) ? d_e : 8'h00;

  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[FA_W] != rp[FA_W]) && (wp[FA_W-1:0] == rp[FA_W-1:0]);
  assign fifo_head  = fifo_mem[rp[FA_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp[FA_W-1:0]] <= {addr[wr_port], d_e};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        addr[i]    <= '0;
        incr[i]    <= 4'd0;
        rdlatch[i] <= 8'h00;
      end
      decr    <= 4'd0;
      sel     <= 2'd0;
      ien     <= 8'h00;
      isr     <= 8'h00;
      rd_pend <= 1'b0;
      rd_addr <= '0;
      rd_port <= 2'd0;
      wp      <= '0;
      rp      <= '0;
    end else begin
      if (push) begin
        wp            <= wp + 1'b1;
        addr[wr_port] <= step_addr(addr[wr_port], incr[wr_port], decr[wr_port]);
      end
      if (wr_en) begin
        case (a_e)
          4'd0: begin
            incr[sel] <= d_e[7:4];
            addr[sel] <= set_byte(addr[sel], 2'd2, d_e);
          end
          4'd1: addr[sel] <= set_byte(addr[sel], 2'd1, d_e);
          4'd2: addr[sel] <= set_byte(addr[sel], 2'd0, d_e);
          4'd3: begin
            sel            <= ctrl_sel;
            decr[ctrl_sel] <= d_e[4];
          end
          4'd4: ien <= d_e;
          default: ;
        endcase
      end
      // A newer read request supersedes one that is still waiting to issue.
      if (rd_start) begin
        rd_addr         <= addr[rd_port_s];
        rd_port         <= rd_port_s;
        rd_pend         <= 1'b1;
        addr[rd_port_s] <= step_addr(addr[rd_port_s], incr[rd_port_s], decr[rd_port_s]);
      end else if (issue_rd) begin
        rd_pend <= 1'b0;
      end
      if (done_wr) rp <= rp + 1'b1;
      if (done_rd) rdlatch[act_port] <= bm_rddata;
      isr <= ((isr & ~isr_clr) | isr_set) & ISR_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Writes stay in the FIFO until acked, so queued writes always precede a later read.
  always_comb begin
    state_nx = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    done_wr  = 1'b0;
    done_rd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          issue_wr = 1'b1;
          state_nx = ST_WR;
        end else if (rd_pend) begin
          issue_rd = 1'b1;
          state_nx = ST_RD;
        end
      end
      ST_WR: if (bm_ack) begin
        done_wr  = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_RD: if (bm_ack) begin
        done_rd  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bm_strobe <= 1'b0;
      bm_write  <= 1'b0;
      bm_addr   <= '0;
      bm_wrdata <= 8'h00;
      act_port  <= 2'd0;
    end else if (issue_wr) begin
      bm_strobe <= 1'b1;
      bm_write  <= 1'b1;
      bm_addr   <= fifo_head[ADDR_W+7:8];
      bm_wrdata <= fifo_head[7:0];
    end else if (issue_rd) begin
      bm_strobe <= 1'b1;
      bm_write  <= 1'b0;
      bm_addr   <= rd_addr;
      act_port  <= rd_port;
    end else if (done_wr || done_rd) begin
      bm_strobe <= 1'b0;
    end
  end

  logic [23:0] sel_addr;
  logic [3:0]  a_off;
  logic [7:0]  rd_mux;

  assign sel_addr = 24'(addr[sel]);
  assign a_off    = extbus_a - DATA_LO;

  always_comb begin
    rd_mux = 8'h00;
    case (extbus_a)
      4'd0: rd_mux = {incr[sel], sel_addr[19:16]};
      4'd1: rd_mux = sel_addr[15:8];
      4'd2: rd_mux = sel_addr[7:0];
      4'd3: rd_mux = {1'b0, rd_pend | (state == ST_RD), ~fifo_empty, decr[sel], 2'b00, sel};
      4'd4: rd_mux = ien;
      4'd5: rd_mux = isr;
      default: begin
        if (extbus_a >= DATA_LO && extbus_a < DATA_HI)
          rd_mux = (done_rd && act_port == a_off[1:0]) ? bm_rddata : rdlatch[a_off[1:0]];
      end
    endcase
  end

  assign extbus_d     = (!extbus_cs_n && extbus_rw_n) ? rd_mux : 8'bz;
  assign extbus_irq_n = (|(isr & ien)) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_extbusif_6502_mp.sv
// Directed bench for extbusif_6502_mp: host register/data accesses against a simple
// bus-master slave model that acks after a programmable delay and logs every transaction.
module tb_extbusif_6502_mp;

  localparam int ADDR_W = 20;

  logic              clk, rst;
  logic              ext_phi2, ext_cs_n, ext_rw_n;
  logic [3:0]        ext_a;
  logic [7:0]        tb_d;
  logic              tb_d_en;
  wire  [7:0]        extbus_d;
  wire               extbus_irq_n;
  logic [ADDR_W-1:0] bm_addr;
  logic [7:0]        bm_wrdata, bm_rddata;
  logic              bm_strobe, bm_write, bm_ack;
  logic [3:0]        irqs;

  assign extbus_d = tb_d_en ? tb_d : 8'bz;
  pullup (extbus_irq_n);

  extbusif_6502_mp #(.NPORTS(2), .ADDR_W(ADDR_W), .WFIFO_DEPTH(4), .NIRQ(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .extbus_phi2(ext_phi2), .extbus_cs_n(ext_cs_n), .extbus_rw_n(ext_rw_n),
    .extbus_a(ext_a), .extbus_d(extbus_d), .extbus_irq_n(extbus_irq_n),
    .bm_addr(bm_addr), .bm_wrdata(bm_wrdata), .bm_rddata(bm_rddata),
    .bm_strobe(bm_strobe), .bm_write(bm_write), .bm_ack(bm_ack), .irqs(irqs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  // Slave model: acks ack_lat cycles after strobe; read data = addr[7:0] ^ 0xC3.
  logic              ack_en;
  int                ack_lat;
  int                wait_cnt = 0;
  int                log_n    = 0;
  int                log_base;
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [7:0]        log_data [0:63];
  logic              log_wr   [0:63];

  always @(negedge clk) begin
    bm_ack = 1'b0;
    if (bm_strobe && ack_en && !rst) begin
      if (wait_cnt >= ack_lat) begin
        bm_ack    = 1'b1;
        bm_rddata = bm_addr[7:0] ^ 8'hC3;
        if (log_n < 64) begin
          log_addr[log_n] = bm_addr;
          log_data[log_n] = bm_wrdata;
          log_wr[log_n]   = bm_write;
        end
        log_n    = log_n + 1;
        wait_cnt = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ext_a = a; ext_rw_n = 1'b0; tb_d = d; tb_d_en = 1'b1; ext_cs_n = 1'b0; ext_phi2 = 1'b1;
    repeat (6) @(negedge clk);
    ext_phi2 = 1'b0;
    repeat (6) @(negedge clk);
    ext_cs_n = 1'b1; tb_d_en = 1'b0; ext_rw_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Data is sampled before the interface can react to the access, as a prefetch read expects.
  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    ext_a = a; ext_rw_n = 1'b1; ext_cs_n = 1'b0; ext_phi2 = 1'b1;
    @(negedge clk);
    d = extbus_d;
    repeat (5) @(negedge clk);
    ext_phi2 = 1'b0;
    repeat (4) @(negedge clk);
    ext_cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_log(input int n, input string what);
    int cyc = 0;
    while ((log_n - log_base) < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if ((log_n - log_base) < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d transactions, required %0d", what, log_n - log_base, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_assert++; if (bm_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b required 0", bm_strobe); end
    n_assert++; if (bm_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b required 0", bm_write); end
    n_assert++; if (bm_addr !== 20'h0) begin n_fail++; $display("FAIL rst_addr: got %h required 00000", bm_addr); end
    n_assert++; if (bm_wrdata !== 8'h00) begin n_fail++; $display("FAIL rst_wrdata: got %h required 00", bm_wrdata); end
    n_assert++; if (extbus_irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq_n: got %b required 1(Z)", extbus_irq_n); end
    bus_read(4'd3, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl: got %h required 00", rd); end
    bus_read(4'd0, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_addr_h: got %h required 00", rd); end
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_isr: got %h required 00", rd); end
  endtask

  task automatic test_write_incr();
    ack_lat = 1; ack_en = 1'b1; log_base = log_n;
    bus_write(4'd3, 8'h00);
    bus_write(4'd0, 8'h10);
    bus_write(4'd1, 8'h10);
    bus_write(4'd2, 8'h00);
    bus_write(4'd6, 8'hAA);
    bus_write(4'd6, 8'hBB);
    wait_log(2, "wr_incr");
    n_assert++; if (log_addr[log_base] !== 20'h01000 || log_data[log_base] !== 8'hAA || log_wr[log_base] !== 1'b1) begin
      n_fail++; $display("FAIL wr0: got addr %h data %h wr %b required 01000 aa 1", log_addr[log_base], log_data[log_base], log_wr[log_base]); end
    n_assert++; if (log_addr[log_base+1] !== 20'h01001 || log_data[log_base+1] !== 8'hBB || log_wr[log_base+1] !== 1'b1) begin
      n_fail++; $display("FAIL wr1: got addr %h data %h wr %b required 01001 bb 1", log_addr[log_base+1], log_data[log_base+1], log_wr[log_base+1]); end
    bus_read(4'd2, rd);
    n_assert++; if (rd !== 8'h02) begin n_fail++; $display("FAIL wr_addr_l: got %h required 02", rd); end
    bus_read(4'd1, rd);
    n_assert++; if (rd !== 8'h10) begin n_fail++; $display("FAIL wr_addr_m: got %h required 10", rd); end
    bus_read(4'd0, rd);
    n_assert++; if (rd !== 8'h10) begin n_fail++; $display("FAIL wr_addr_h: got %h required 10", rd); end
  endtask

  task automatic test_read_decr();
    ack_lat = 1; ack_en = 1'b1; log_base = log_n;
    bus_write(4'd3, 8'h01);
    bus_write(4'd3, 8'h11);
    bus_write(4'd0, 8'h50);
    bus_write(4'd1, 8'h00);
    bus_write(4'd2, 8'h10);
    bus_read(4'd3, rd);
    n_assert++; if (rd !== 8'h11) begin n_fail++; $display("FAIL rd_ctrl: got %h required 11", rd); end
    bus_read(4'd7, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rd_first: got %h required 00", rd); end
    wait_log(1, "rd_first");
    n_assert++; if (log_addr[log_base] !== 20'h00010 || log_wr[log_base] !== 1'b0) begin
      n_fail++; $display("FAIL rd_addr0: got addr %h wr %b required 00010 0", log_addr[log_base], log_wr[log_base]); end
    bus_read(4'd7, rd);
    n_assert++; if (rd !== 8'hD3) begin n_fail++; $display("FAIL rd_second: got %h required d3", rd); end
    wait_log(2, "rd_second");
    n_assert++; if (log_addr[log_base+1] !== 20'h00000 || log_wr[log_base+1] !== 1'b0) begin
      n_fail++; $display("FAIL rd_addr1: got addr %h wr %b required 00000 0", log_addr[log_base+1], log_wr[log_base+1]); end
    bus_read(4'd2, rd);
    n_assert++; if (rd !== 8'hF0) begin n_fail++; $display("FAIL rd_wrap_l: got %h required f0", rd); end
    bus_read(4'd1, rd);
    n_assert++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL rd_wrap_m: got %h required ff", rd); end
    bus_read(4'd0, rd);
    n_assert++; if (rd !== 8'h5F) begin n_fail++; $display("FAIL rd_wrap_h: got %h required 5f", rd); end
  endtask

  task automatic test_fifo_overflow();
    bus_write(4'd3, 8'h00);
    bus_write(4'd0, 8'h10);
    bus_write(4'd1, 8'h01);
    bus_write(4'd2, 8'h00);
    bus_write(4'd4, 8'h80);
    ack_en = 1'b0; log_base = log_n;
    for (int i = 1; i <= 5; i++) bus_write(4'd6, 8'(i));
    n_assert++; if (bm_strobe !== 1'b1 || bm_write !== 1'b1 || bm_addr !== 20'h00100 || bm_wrdata !== 8'h01) begin
      n_fail++; $display("FAIL ovf_stall: got stb %b wr %b addr %h data %h required 1 1 00100 01", bm_strobe, bm_write, bm_addr, bm_wrdata); end
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h80) begin n_fail++; $display("FAIL ovf_isr: got %h required 80", rd); end
    n_assert++; if (extbus_irq_n !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_n: got %b required 0", extbus_irq_n); end
    bus_read(4'd2, rd);
    n_assert++; if (rd !== 8'h04) begin n_fail++; $display("FAIL ovf_addr_l: got %h required 04", rd); end
    bus_read(4'd3, rd);
    n_assert++; if (rd !== 8'h20) begin n_fail++; $display("FAIL ovf_ctrl: got %h required 20", rd); end
    ack_en = 1'b1;
    wait_log(4, "ovf_drain");
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (log_addr[log_base+i] !== 20'h00100 + 20'(i) || log_data[log_base+i] !== 8'(i + 1) || log_wr[log_base+i] !== 1'b1) begin
        n_fail++; $display("FAIL ovf_entry%0d: got addr %h data %h required %h %h", i, log_addr[log_base+i], log_data[log_base+i], 20'h00100 + 20'(i), 8'(i + 1)); end
    end
    repeat (20) @(negedge clk);
    n_assert++; if (log_n - log_base !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d required 4", log_n - log_base); end
    bus_write(4'd5, 8'h80);
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL ovf_isr_clr: got %h required 00", rd); end
    n_assert++; if (extbus_irq_n !== 1'b1) begin n_fail++; $display("FAIL ovf_irq_clr: got %b required 1(Z)", extbus_irq_n); end
  endtask

  task automatic test_back_to_back();
    ack_en = 1'b0; log_base = log_n;
    bus_write(4'd6, 8'h11);
    bus_write(4'd6, 8'h22);
    bus_read(4'd6, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL ord_latch: got %h required 00", rd); end
    bus_read(4'd3, rd);
    n_assert++; if (rd !== 8'h60) begin n_fail++; $display("FAIL ord_ctrl: got %h required 60", rd); end
    n_assert++; if (bm_write !== 1'b1 || bm_addr !== 20'h00104) begin
      n_fail++; $display("FAIL ord_stall: got wr %b addr %h required 1 00104", bm_write, bm_addr); end
    ack_en = 1'b1;
    wait_log(3, "ord_drain");
    n_assert++; if (log_wr[log_base] !== 1'b1 || log_addr[log_base] !== 20'h00104 || log_data[log_base] !== 8'h11) begin
      n_fail++; $display("FAIL ord_t0: got wr %b addr %h data %h required 1 00104 11", log_wr[log_base], log_addr[log_base], log_data[log_base]); end
    n_assert++; if (log_wr[log_base+1] !== 1'b1 || log_addr[log_base+1] !== 20'h00105 || log_data[log_base+1] !== 8'h22) begin
      n_fail++; $display("FAIL ord_t1: got wr %b addr %h data %h required 1 00105 22", log_wr[log_base+1], log_addr[log_base+1], log_data[log_base+1]); end
    n_assert++; if (log_wr[log_base+2] !== 1'b0 || log_addr[log_base+2] !== 20'h00106) begin
      n_fail++; $display("FAIL ord_t2: got wr %b addr %h required 0 00106", log_wr[log_base+2], log_addr[log_base+2]); end
    bus_read(4'd3, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL ord_ctrl_idle: got %h required 00", rd); end
    bus_read(4'd6, rd);
    n_assert++; if (rd !== 8'hC5) begin n_fail++; $display("FAIL ord_rdata: got %h required c5", rd); end
    wait_log(4, "ord_rd2");
    bus_read(4'd2, rd);
    n_assert++; if (rd !== 8'h08) begin n_fail++; $display("FAIL ord_addr_l: got %h required 08", rd); end
  endtask

  task automatic test_irq();
    bus_write(4'd4, 8'h01);
    @(negedge clk); irqs = 4'b0001;
    repeat (2) @(negedge clk); irqs = 4'b0000;
    @(negedge clk);
    n_assert++; if (extbus_irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_assert: got %b required 0", extbus_irq_n); end
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h01) begin n_fail++; $display("FAIL irq_isr: got %h required 01", rd); end
    irqs = 4'b0001;
    bus_write(4'd5, 8'h01);
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h01) begin n_fail++; $display("FAIL irq_set_wins: got %h required 01", rd); end
    irqs = 4'b0000;
    bus_write(4'd5, 8'h01);
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL irq_clear: got %h required 00", rd); end
    n_assert++; if (extbus_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_release: got %b required 1(Z)", extbus_irq_n); end
    @(negedge clk); irqs = 4'b1000;
    @(negedge clk); irqs = 4'b0000;
    bus_read(4'd5, rd);
    n_assert++; if (rd !== 8'h08) begin n_fail++; $display("FAIL irq_isr3: got %h required 08", rd); end
    n_assert++; if (extbus_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_masked: got %b required 1(Z)", extbus_irq_n); end
    bus_write(4'd5, 8'h08);
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    bus_write(4'd6, 8'h77);
    bus_write(4'd6, 8'h78);
    n_assert++; if (bm_strobe !== 1'b1) begin n_fail++; $display("FAIL mid_pre_strobe: got %b required 1", bm_strobe); end
    @(negedge clk); rst = 1'b1;
    #1;
    n_assert++; if (bm_strobe !== 1'b0 || bm_write !== 1'b0 || bm_addr !== 20'h0 || bm_wrdata !== 8'h00) begin
      n_fail++; $display("FAIL mid_rst_bm: got stb %b wr %b addr %h data %h required 0 0 00000 00", bm_strobe, bm_write, bm_addr, bm_wrdata); end
    repeat (2) @(negedge clk); rst = 1'b0;
    ack_en = 1'b1; log_base = log_n;
    repeat (15) @(negedge clk);
    n_assert++; if (bm_strobe !== 1'b0 || log_n - log_base !== 0) begin
      n_fail++; $display("FAIL mid_no_strobe: got stb %b trans %0d required 0 0", bm_strobe, log_n - log_base); end
    bus_read(4'd3, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_ctrl: got %h required 00", rd); end
    bus_read(4'd0, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_addr_h: got %h required 00", rd); end
    bus_read(4'd2, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_addr_l: got %h required 00", rd); end
    bus_read(4'd4, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_ien: got %h required 00", rd); end
    bus_read(4'd6, rd);
    n_assert++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_rdlatch: got %h required 00", rd); end
  endtask

  initial begin
    rst = 1'b1; ext_phi2 = 1'b0; ext_cs_n = 1'b1; ext_rw_n = 1'b1; ext_a = 4'd0;
    tb_d = 8'h00; tb_d_en = 1'b0; irqs = 4'b0000; ack_en = 1'b0; ack_lat = 1; log_base = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_incr();
    test_read_decr();
    test_fifo_overflow();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
